// File: rtl/clk_pkg.sv
// clk_pkg: constants and helpers shared by the clock-derivation block.
//   DEFAULT_CLK_FREQ_HZ / DEFAULT_PERIOD_MS : default parameter values
//   full_count / half_count                 : clocks per output period / half period
//   counter_width                           : half-period counter width (minimum 1 bit)
package clk_pkg;

    localparam longint unsigned DEFAULT_CLK_FREQ_HZ = 64'd100_000_000;
    localparam longint unsigned DEFAULT_PERIOD_MS   = 64'd100;

    // 64-bit arithmetic keeps large frequency/period products from overflowing.
    function automatic longint unsigned full_count(input longint unsigned freq_hz,
                                                   input longint unsigned period_ms);
        return (freq_hz / 64'd1000) * period_ms;
    endfunction

    function automatic longint unsigned half_count(input longint unsigned freq_hz,
                                                   input longint unsigned period_ms);
        return full_count(freq_hz, period_ms) / 64'd2;
    endfunction

    function automatic int unsigned counter_width(input longint unsigned half);
        return (half > 64'd1) ? int'($clog2(half)) : 1;
    endfunction

endpackage

// File: rtl/period_toggle.sv
// period_toggle: 50 %-duty square wave that inverts every HALF_COUNT clocks,
// plus a registered one-cycle tick on each rising edge of the wave.
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   wave : square wave, period 2*HALF_COUNT clocks, starts low
//   tick : high for the one cycle following each 0->1 edge of wave
module period_toggle
    import clk_pkg::*;
#(
    parameter longint unsigned HALF_COUNT = 64'd5
) (
    input  logic clk,
    input  logic rst,
    output logic wave,
    output logic tick
);

    localparam int unsigned    W    = counter_width(HALF_COUNT);
    localparam logic [W-1:0]   LAST = W'(HALF_COUNT - 64'd1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wave_q, wave_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + W'(1);
        wave_d = wave_q;
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
            // The wave is about to go 0->1 exactly when it is currently low.
            tick_d = ~wave_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            tick_q <= tick_d;
        end
    end

    assign wave = wave_q;
    assign tick = tick_q;

endmodule

// File: rtl/clk_div_100ms.sv
// clk_div_100ms: clock-derivation block for the game core.
//   clk        : system clock (CLK_FREQ_HZ)
//   rst        : asynchronous reset, active-high
//   clk_div    : free-running 32-bit cycle counter, wraps mod 2^32
//   clk_100ms  : 50 %-duty square wave of period PERIOD_MS
//   tick_100ms : one-cycle pulse after each rising edge of clk_100ms
module clk_div_100ms
    import clk_pkg::*;
#(
    parameter longint unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter longint unsigned PERIOD_MS   = DEFAULT_PERIOD_MS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] clk_div,
    output logic        clk_100ms,
    output logic        tick_100ms
);

    localparam longint unsigned FULL_COUNT = full_count(CLK_FREQ_HZ, PERIOD_MS);
    localparam longint unsigned HALF_COUNT = half_count(CLK_FREQ_HZ, PERIOD_MS);

    if ((FULL_COUNT % 64'd2 != 64'd0) || (FULL_COUNT < 64'd2)) begin : g_bad_params
        $error("clk_div_100ms: FULL_COUNT (%0d) must be even and >= 2", FULL_COUNT);
    end

    logic [31:0] clk_div_q, clk_div_d;

    always_comb begin
        clk_div_d = clk_div_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div_q <= '0;
        end else begin
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div = clk_div_q;

    period_toggle #(
        .HALF_COUNT(HALF_COUNT)
    ) u_period_toggle (
        .clk  (clk),
        .rst  (rst),
        .wave (clk_100ms),
        .tick (tick_100ms)
    );

endmodule

// File: tb/tb_clk_div_100ms.sv
module tb_clk_div_100ms;

    localparam longint A_HALF = 5;   // 1000 Hz, 10 ms  -> FULL 10
    localparam longint B_HALF = 32;  // 64 kHz, 1 ms    -> FULL 64

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] div_a, div_b;
    logic        wave_a, wave_b, tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release, plus an offset for
    // the A counter after it has been forced.
    longint      k = 0;
    logic [31:0] base_a = '0;

    always #5 clk = ~clk;

    clk_div_100ms #(.CLK_FREQ_HZ(1000), .PERIOD_MS(10)) dut_a (
        .clk(clk), .rst(rst), .clk_div(div_a), .clk_100ms(wave_a), .tick_100ms(tick_a)
    );

    clk_div_100ms #(.CLK_FREQ_HZ(64000), .PERIOD_MS(1)) dut_b (
        .clk(clk), .rst(rst), .clk_div(div_b), .clk_100ms(wave_b), .tick_100ms(tick_b)
    );

    // Wave is high during odd-numbered half periods counted from release.
    function automatic logic exp_wave(input longint kk, input longint half);
        return ((kk / half) % 2) == 1;
    endfunction

    // Tick follows edges HALF + n*FULL.
    function automatic logic exp_tick(input longint kk, input longint half);
        return (kk >= half) && (((kk - half) % (2 * half)) == 0);
    endfunction

    function automatic logic [33:0] exp_a();
        return {base_a + 32'(k), exp_wave(k, A_HALF), exp_tick(k, A_HALF)};
    endfunction

    function automatic logic [33:0] exp_b();
        return {32'(k), exp_wave(k, B_HALF), exp_tick(k, B_HALF)};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) k++;
        #1;
    endtask

    task automatic assert_rst();
        rst    = 1'b1;
        k      = 0;
        base_a = '0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        assert_rst();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({div_a, wave_a, tick_a} !== 34'd0 || {div_b, wave_b, tick_b} !== 34'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: a=%h b=%h required 0", i,
                         {div_a, wave_a, tick_a}, {div_b, wave_b, tick_b});
            end
        end
        release_rst();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (div_a !== 32'(i) || div_b !== 32'(i)) begin
                errors++;
                $display("FAIL reset_release edge%0d: div_a=%0d div_b=%0d required %0d",
                         i, div_a, div_b, i);
            end
        end
    endtask

    task automatic test_waveform();
        while (k < 140) begin
            step();
            checks++;
            if ({div_a, wave_a, tick_a} !== exp_a()) begin
                errors++;
                $display("FAIL wave_a edge%0d: got %h required %h", k,
                         {div_a, wave_a, tick_a}, exp_a());
            end
            checks++;
            if ({div_b, wave_b, tick_b} !== exp_b()) begin
                errors++;
                $display("FAIL wave_b edge%0d: got %h required %h", k,
                         {div_b, wave_b, tick_b}, exp_b());
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        assert_rst();
        release_rst();
        repeat (7) step();
        #2;  // strictly between edges 7 and 8
        assert_rst();
        #1;
        checks++;
        if ({div_a, wave_a, tick_a} !== 34'd0 || {div_b, wave_b, tick_b} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: a=%h b=%h required 0",
                     {div_a, wave_a, tick_a}, {div_b, wave_b, tick_b});
        end
        step();
        checks++;
        if ({div_a, wave_a, tick_a} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset_hold: a=%h required 0", {div_a, wave_a, tick_a});
        end
        release_rst();
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if ({div_a, wave_a, tick_a} !== exp_a()) begin
                errors++;
                $display("FAIL async_restart edge%0d: got %h required %h", i,
                         {div_a, wave_a, tick_a}, exp_a());
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut_a.clk_div_q = 32'hFFFF_FFFE;
        #1;
        release dut_a.clk_div_q;
        base_a = 32'hFFFF_FFFE - 32'(k);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({div_a, wave_a, tick_a} !== exp_a()) begin
                errors++;
                $display("FAIL wrap step%0d: got %h required %h", i,
                         {div_a, wave_a, tick_a}, exp_a());
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int run_len = int'($urandom_range(1, 90));
            for (int j = 0; j < run_len; j++) begin
                step();
                checks++;
                if ({div_a, wave_a, tick_a} !== exp_a() || {div_b, wave_b, tick_b} !== exp_b()) begin
                    errors++;
                    $display("FAIL random it%0d edge%0d: a=%h/%h b=%h/%h", it, k,
                             {div_a, wave_a, tick_a}, exp_a(), {div_b, wave_b, tick_b}, exp_b());
                end
            end
            if ($urandom_range(0, 2) != 0) begin
                #($urandom_range(1, 7));
                assert_rst();
                #0.5;
                checks++;
                if ({div_a, wave_a, tick_a} !== 34'd0 || {div_b, wave_b, tick_b} !== 34'd0) begin
                    errors++;
                    $display("FAIL random_reset it%0d: a=%h b=%h required 0", it,
                             {div_a, wave_a, tick_a}, {div_b, wave_b, tick_b});
                end
                repeat ($urandom_range(0, 2)) step();
                release_rst();
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_waveform();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
